// File: rtl/core_run_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | core_run_sequencer: streams a program image into imem, then runs the core  |
// | until ECALL/EBREAK, external stop or cycle timeout.  Rev 1.0               |
// +----------------------------------------------------------------------------+
module core_run_sequencer #(
    parameter int unsigned ADDR_W     = 8,
    parameter int unsigned CYC_W      = 32,
    parameter int unsigned MAX_CYCLES = 0
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              load_start_i,
    input  logic              run_start_i,
    input  logic              run_stop_i,
    input  logic              ld_valid_i,
    output logic              ld_ready_o,
    input  logic [31:0]       ld_data_i,
    input  logic              ld_last_i,
    output logic              imem_we_o,
    output logic [ADDR_W-1:0] imem_addr_o,
    output logic [31:0]       imem_wdata_o,
    output logic              core_rst_o,
    input  logic [31:0]       core_pc_i,
    input  logic [31:0]       core_instr_i,
    output logic [CYC_W-1:0]  cycle_count_o,
    output logic [31:0]       halt_pc_o,
    output logic              halted_o,
    output logic              timeout_o,
    output logic              load_ovf_o
);
    localparam logic [ADDR_W-1:0] PTR_LAST     = {ADDR_W{1'b1}};
    localparam logic [CYC_W-1:0]  CNT_MAX      = {CYC_W{1'b1}};
    localparam bit                TMO_EN       = (MAX_CYCLES != 0);
    // Count value seen during the final permitted run cycle; meaningless when disabled.
    localparam logic [CYC_W-1:0]  TMO_AT       = CYC_W'(MAX_CYCLES - 1);
    localparam logic [31:0]       INSTR_ECALL  = 32'h0000_0073;
    localparam logic [31:0]       INSTR_EBREAK = 32'h0010_0073;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2,
        ST_HALT = 2'd3
    } state_e;

    state_e             state_q, state_d;
    logic [ADDR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [CYC_W-1:0]   cyc_q, cyc_d;
    logic [31:0]        halt_pc_q, halt_pc_d;
    logic               core_rst_q, core_rst_d;
    logic               halted_q, halted_d;
    logic               timeout_q, timeout_d;
    logic               load_ovf_q, load_ovf_d;
    logic               ld_accept;
    logic               tmo_hit;
    logic               halt_req;

    always_comb begin
        ld_accept  = (state_q == ST_LOAD) && ld_valid_i;
        tmo_hit    = TMO_EN && (cyc_q == TMO_AT);
        halt_req   = (core_instr_i == INSTR_ECALL) || (core_instr_i == INSTR_EBREAK)
                     || run_stop_i || tmo_hit;

        state_d    = state_q;
        wr_ptr_d   = wr_ptr_q;
        cyc_d      = cyc_q;
        halt_pc_d  = halt_pc_q;
        core_rst_d = core_rst_q;
        halted_d   = halted_q;
        timeout_d  = timeout_q;
        load_ovf_d = load_ovf_q;

        case (state_q)
            ST_IDLE, ST_HALT: begin
                if (load_start_i) begin
                    state_d    = ST_LOAD;
                    wr_ptr_d   = '0;
                    cyc_d      = '0;
                    halt_pc_d  = '0;
                    halted_d   = 1'b0;
                    timeout_d  = 1'b0;
                    load_ovf_d = 1'b0;
                end else if (run_start_i) begin
                    state_d    = ST_RUN;
                    core_rst_d = 1'b0;
                    cyc_d      = '0;
                    halted_d   = 1'b0;
                    timeout_d  = 1'b0;
                end
            end
            ST_LOAD: begin
                if (ld_accept) begin
                    // The pointer parks on the last word rather than wrapping.
                    if (wr_ptr_q != PTR_LAST) begin
                        wr_ptr_d = wr_ptr_q + ADDR_W'(1);
                    end
                    if (ld_last_i) begin
                        state_d    = ST_RUN;
                        core_rst_d = 1'b0;
                    end else if (wr_ptr_q == PTR_LAST) begin
                        state_d    = ST_RUN;
                        core_rst_d = 1'b0;
                        load_ovf_d = 1'b1;
                    end
                end
            end
            ST_RUN: begin
                if (cyc_q != CNT_MAX) begin
                    cyc_d = cyc_q + CYC_W'(1);
                end
                if (halt_req) begin
                    state_d    = ST_HALT;
                    halt_pc_d  = core_pc_i;
                    core_rst_d = 1'b1;
                    halted_d   = 1'b1;
                    timeout_d  = tmo_hit;
                end
            end
            default: begin
                state_d    = ST_IDLE;
                core_rst_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= ST_IDLE;
            wr_ptr_q   <= '0;
            cyc_q      <= '0;
            halt_pc_q  <= '0;
            core_rst_q <= 1'b1;
            halted_q   <= 1'b0;
            timeout_q  <= 1'b0;
            load_ovf_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            cyc_q      <= cyc_d;
            halt_pc_q  <= halt_pc_d;
            core_rst_q <= core_rst_d;
            halted_q   <= halted_d;
            timeout_q  <= timeout_d;
            load_ovf_q <= load_ovf_d;
        end
    end

    assign ld_ready_o    = (state_q == ST_LOAD);
    assign imem_we_o     = ld_accept;
    assign imem_addr_o   = wr_ptr_q;
    assign imem_wdata_o  = ld_data_i;
    assign core_rst_o    = core_rst_q;
    assign cycle_count_o = cyc_q;
    assign halt_pc_o     = halt_pc_q;
    assign halted_o      = halted_q;
    assign timeout_o     = timeout_q;
    assign load_ovf_o    = load_ovf_q;

endmodule
`default_nettype wire
